// File: rtl/mig_app_responder.sv
// On-chip responder for the MIG 7-series app_* interface: calibration delay, command
// back-pressure, a write-data FIFO and fixed-latency in-order reads over a small array.
//
// state | meaning
// CALIB | counting up to CALIB_CYCLES after reset; app_rdy and app_wdf_rdy held low
// RUN   | calibrated; commands and write beats accepted, LFSR free-running
module mig_app_responder #(
    parameter int          DDR_DATA_WIDTH = 128,
    parameter int          DDR_ADDR_WIDTH = 28,
    parameter int          MEM_ADDR_BITS  = 8,
    parameter int          RD_LATENCY     = 6,
    parameter int          CALIB_CYCLES   = 64,
    parameter int          WDF_DEPTH      = 4,
    parameter int          STALL_EN       = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        init_calib_complete,
    input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]                  app_cmd,
    input  logic                        app_en,
    output logic                        app_rdy,
    input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                        app_wdf_wren,
    input  logic                        app_wdf_end,
    output logic                        app_wdf_rdy,
    output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
    output logic                        app_rd_data_valid,
    output logic                        app_rd_data_end,
    output logic                        proto_err
);

    localparam int NBYTES = DDR_DATA_WIDTH / 8;
    localparam int PW     = $clog2(WDF_DEPTH);
    localparam int CW     = $clog2(CALIB_CYCLES + 1);
    localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);
    localparam logic [PW:0]   FIFO_FULL  = (PW + 1)'(WDF_DEPTH);

    typedef enum logic {CALIB, RUN} state_t;

    state_t                     state;
    logic [CW-1:0]              calib_cnt;
    logic [15:0]                lfsr;
    logic                       wr_pending;
    logic [MEM_ADDR_BITS-1:0]   wr_idx;

    logic [DDR_DATA_WIDTH-1:0]        mem [2**MEM_ADDR_BITS];
    logic [NBYTES+DDR_DATA_WIDTH-1:0] fifo [WDF_DEPTH];
    logic [PW-1:0]                    fifo_wr_ptr;
    logic [PW-1:0]                    fifo_rd_ptr;
    logic [PW:0]                      fifo_count;

    logic [DDR_DATA_WIDTH-1:0] pipe_data [RD_LATENCY];
    logic [RD_LATENCY-1:0]     pipe_valid;

    logic                      stall;
    logic                      fifo_empty;
    logic                      cmd_take;
    logic                      is_wr;
    logic                      is_rd;
    logic                      is_bad;
    logic                      push;
    logic                      commit;
    logic [MEM_ADDR_BITS-1:0]  cmd_idx;
    logic [MEM_ADDR_BITS-1:0]  commit_idx;
    logic [DDR_DATA_WIDTH-1:0] head_data;
    logic [NBYTES-1:0]         head_mask;
    logic                      lfsr_fb;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{app_addr[DDR_ADDR_WIDTH-1:MEM_ADDR_BITS+3], app_addr[2:0]};

    assign stall       = (STALL_EN != 0) && (lfsr[1:0] == 2'b00);
    assign fifo_empty  = (fifo_count == '0);
    assign app_rdy     = init_calib_complete & ~wr_pending & ~stall;
    assign app_wdf_rdy = init_calib_complete & (fifo_count != FIFO_FULL);

    assign cmd_take = app_en & app_rdy;
    assign is_wr    = cmd_take && (app_cmd == 3'b000);
    assign is_rd    = cmd_take && (app_cmd == 3'b001);
    assign is_bad   = cmd_take && (app_cmd != 3'b000) && (app_cmd != 3'b001);
    assign push     = app_wdf_wren & app_wdf_rdy;
    assign cmd_idx  = app_addr[MEM_ADDR_BITS+2:3];

    // A write commits either on its own accept edge (data already queued) or on the
    // edge after its beat lands; wr_pending blocks app_rdy so the two never overlap.
    assign commit     = ~fifo_empty & (is_wr | wr_pending);
    assign commit_idx = wr_pending ? wr_idx : cmd_idx;
    assign head_data  = fifo[fifo_rd_ptr][DDR_DATA_WIDTH-1:0];
    assign head_mask  = fifo[fifo_rd_ptr][NBYTES+DDR_DATA_WIDTH-1:DDR_DATA_WIDTH];
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= CALIB;
            calib_cnt           <= '0;
            init_calib_complete <= 1'b0;
            lfsr                <= LFSR_SEED;
            wr_pending          <= 1'b0;
            wr_idx              <= '0;
            proto_err           <= 1'b0;
        end else begin
            case (state)
                CALIB: begin
                    calib_cnt <= calib_cnt + 1'b1;
                    if (calib_cnt == CALIB_LAST) begin
                        state               <= RUN;
                        init_calib_complete <= 1'b1;
                    end
                end
                RUN: lfsr <= {lfsr[14:0], lfsr_fb};
                default: state <= CALIB;
            endcase

            if (is_wr && fifo_empty) begin
                wr_pending <= 1'b1;
                wr_idx     <= cmd_idx;
            end else if (wr_pending && !fifo_empty) begin
                wr_pending <= 1'b0;
            end

            if (is_bad || (app_wdf_wren != app_wdf_end) ||
                (!init_calib_complete && (app_wdf_wren || app_en))) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (push) fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            if (commit) fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            fifo_count <= fifo_count + {{PW{1'b0}}, push} - {{PW{1'b0}}, commit};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[fifo_wr_ptr] <= {app_wdf_mask, app_wdf_data};
    end

    // Array has no reset; a commit coinciding with rst is dropped with the rest of the state.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (!head_mask[b]) mem[commit_idx][b*8 +: 8] <= head_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
        end else begin
            pipe_valid   <= {pipe_valid[RD_LATENCY-2:0], is_rd};
            pipe_data[0] <= is_rd ? mem[cmd_idx] : '0;
            for (int i = 1; i < RD_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
        end
    end

    assign app_rd_data       = pipe_data[RD_LATENCY-1];
    assign app_rd_data_valid = pipe_valid[RD_LATENCY-1];
    assign app_rd_data_end   = pipe_valid[RD_LATENCY-1];

endmodule
